// File: rtl/display_pkg.sv
// Shared types and helpers for the score display path.
// Provides the scan FSM state type, the blank segment pattern and the hex digit decoder.
package display_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHOW_LO = 3'd1,
    GAP_HI  = 3'd2,
    SHOW_HI = 3'd3,
    GAP_LO  = 3'd4
  } scan_state_e;

  localparam logic [6:0] SEG_OFF  = 7'h00;
  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_LO   = 2'b01;
  localparam logic [1:0] SEL_HI   = 2'b10;

  // Segment order is {g,f,e,d,c,b,a}, active-high.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Bundle between the game core (master) and the display scan controller (slave).
// Carries the digit/control inputs and the segment, digit-select and millisecond outputs.
interface seg_scan_ctrl_if;
  logic [15:0] ticks_per_milli;
  logic        enable;
  logic [3:0]  digit_hi;
  logic [3:0]  digit_lo;
  logic        load;
  logic        blank_lead;
  logic        blink;
  logic        segments_invert;
  logic [6:0]  segments;
  logic [1:0]  segment_digits;
  logic        milli_tick;

  modport master (
    output ticks_per_milli, enable, digit_hi, digit_lo, load,
           blank_lead, blink, segments_invert,
    input  segments, segment_digits, milli_tick
  );

  modport slave (
    input  ticks_per_milli, enable, digit_hi, digit_lo, load,
           blank_lead, blink, segments_invert,
    output segments, segment_digits, milli_tick
  );
endinterface

// File: rtl/tick_prescaler.sv
// Free-running millisecond prescaler: registered one-cycle tick every ticks_per_milli cycles.
// A period of 0 or 1 ticks every cycle; shrinking the period below the count wraps next cycle.
module tick_prescaler (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ticks_per_milli,
  output logic        tick
);

  logic [15:0] cnt_q, cnt_d;
  logic        tick_q, tick_d;
  logic        terminal;

  always_comb begin
    terminal = (ticks_per_milli <= 16'd1) || (cnt_q >= ticks_per_milli - 16'd1);
    tick_d   = terminal;
    cnt_d    = terminal ? 16'd0 : cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 16'd0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Two-digit seven-segment scan controller with dead-time blanking, frame-synchronous
// digit update, leading-zero suppression and blink.
module seg_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned DWELL_MS    = 4,
  parameter int unsigned BLANK_TICKS = 2,
  parameter int unsigned BLINK_MS    = 250
) (
  input  logic               clk,
  input  logic               rst,
  seg_scan_ctrl_if.slave     bus
);

  localparam int DWELL_W = (DWELL_MS    > 1) ? $clog2(DWELL_MS)    : 1;
  localparam int GAP_W   = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS) : 1;
  localparam int BLINK_W = (BLINK_MS    > 1) ? $clog2(BLINK_MS)    : 1;

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_MS - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(BLANK_TICKS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_MS - 1);

  logic milli_tick;

  scan_state_e        state_q, state_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               phase_q, phase_d;
  logic [3:0]         pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic [3:0]         disp_hi_q, disp_hi_d, disp_lo_q, disp_lo_d;
  logic [6:0]         seg_q, seg_d;
  logic [1:0]         sel_q, sel_d;
  logic               frame_start;

  tick_prescaler u_prescaler (
    .clk             (clk),
    .rst             (rst),
    .ticks_per_milli (bus.ticks_per_milli),
    .tick            (milli_tick)
  );

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    gap_d   = gap_q;
    if (!bus.enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SHOW_LO;
          dwell_d = '0;
        end
        SHOW_LO, SHOW_HI: begin
          if (milli_tick) begin
            if (dwell_q == DWELL_LAST) begin
              state_d = (state_q == SHOW_LO) ? GAP_HI : GAP_LO;
              gap_d   = '0;
            end else begin
              dwell_d = dwell_q + DWELL_W'(1);
            end
          end
        end
        GAP_HI, GAP_LO: begin
          if (gap_q == GAP_LAST) begin
            state_d = (state_q == GAP_HI) ? SHOW_HI : SHOW_LO;
            dwell_d = '0;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Display digits only change at a frame boundary; a coincident load bypasses pending.
  always_comb begin
    pend_hi_d   = bus.load ? bus.digit_hi : pend_hi_q;
    pend_lo_d   = bus.load ? bus.digit_lo : pend_lo_q;
    frame_start = (state_d == SHOW_LO) && (state_q != SHOW_LO);
    disp_hi_d   = frame_start ? pend_hi_d : disp_hi_q;
    disp_lo_d   = frame_start ? pend_lo_d : disp_lo_q;
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (!bus.blink) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (milli_tick) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end
  end

  // Select and segments are both registered from state_q so they move on the same edge.
  always_comb begin
    sel_d = SEL_NONE;
    seg_d = SEG_OFF;
    case (state_q)
      SHOW_LO: begin
        sel_d = SEL_LO;
        seg_d = hex_to_seg(disp_lo_q);
      end
      SHOW_HI: begin
        sel_d = SEL_HI;
        if (!(bus.blank_lead && (disp_hi_q == 4'h0))) begin
          seg_d = hex_to_seg(disp_hi_q);
        end
      end
      default: ;
    endcase
    if (phase_q) begin
      seg_d = SEG_OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      dwell_q     <= '0;
      gap_q       <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      pend_hi_q   <= 4'h0;
      pend_lo_q   <= 4'h0;
      disp_hi_q   <= 4'h0;
      disp_lo_q   <= 4'h0;
      seg_q       <= SEG_OFF;
      sel_q       <= SEL_NONE;
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      gap_q       <= gap_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      pend_hi_q   <= pend_hi_d;
      pend_lo_q   <= pend_lo_d;
      disp_hi_q   <= disp_hi_d;
      disp_lo_q   <= disp_lo_d;
      seg_q       <= seg_d;
      sel_q       <= sel_d;
    end
  end

  assign bus.segments       = seg_q ^ {7{bus.segments_invert}};
  assign bus.segment_digits = sel_q;
  assign bus.milli_tick     = milli_tick;

endmodule
